fetch_seq: RTL and testbench
============================

# fetch_seq

Parametrised successor to the processor's fetch unit. It produces the program counter for the instruction ROM and adds a run/halt state machine, stall support, absolute or PC-relative branches, and call/return through a return-address stack (RAS). It sits between control/ALU branch outputs and `instr_rom.pc`, and is driven by the same `start_i` / `start_address_i` bring-up protocol.

## Interface
- `PC_WIDTH`, 16, PC and branch-target width.
- `STEP`, 1, PC increment per sequential instruction.
- `RAS_DEPTH`, 4, return-address stack entries (≥2).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start_i`  in  1  load `start_address_i` and run.
- `start_address_i`  in  PC_WIDTH  restart address.
- `halt_i`  in  1  stop fetching.
- `stall_i`  in  1  hold PC this cycle.
- `branch_i`  in  1  taken branch.
- `branch_mode_i`  in  1  0 = absolute target, 1 = PC-relative (two's-complement offset).
- `branchloc_i`  in  PC_WIDTH  target or offset.
- `call_i`  in  1  branch per `branch_mode_i` and push return address.
- `ret_i`  in  1  pop RAS into PC.
- `pc_o`  out  PC_WIDTH  current PC.
- `pc_valid_o`  out  1  high when state is RUN.
- `state_o`  out  2  IDLE=0, RUN=1, HALT=2.
- `ras_overflow_o`  out  1  sticky: push while full.
- `ras_underflow_o`  out  1  sticky: pop while empty.

## Operation
- **Reset values:** state IDLE, `pc_o` 0, `pc_valid_o` 0, RAS empty, both sticky flags 0.
- **IDLE:**
  - `start_i` → RUN with `pc_o` = `start_address_i`.
  - All other inputs are ignored.
- **RUN:** exactly one action per cycle, by priority:
  1. `start_i`: reload start address, empty the RAS, clear sticky flags.
  2. `halt_i`: go to HALT; PC holds.
  3. `stall_i`: PC and RAS hold.
  4. `ret_i`: PC = RAS top, pop.
  5. `call_i`: push PC+STEP, PC = target.
  6. `branch_i`: PC = target.
  7. Otherwise: PC = PC+STEP.
- **Target:** `branchloc_i` if `branch_mode_i`=0, else PC+`branchloc_i`.
- **Arithmetic:** all PC arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- **HALT:**
  - PC holds; `pc_valid_o` is 0.
  - `start_i` → RUN with the start address; the RAS is emptied and flags are cleared.
- **Holding `start_i`:** while `start_i` stays high, PC reloads the start address every cycle. Sequencing begins on the first cycle after it falls.
- **RAS full:** a push discards the oldest entry (circular). Depth stays RAS_DEPTH and `ras_overflow_o` sets.
- **RAS empty:** a pop gives PC = PC+STEP and sets `ras_underflow_o`.
- **Simultaneous requests:** `ret_i` with `call_i` → ret wins and the call is dropped. `call_i` with `branch_i` → treated as a call.

## Timing
- All inputs are sampled on the rising `clk` edge. `pc_o`, `state_o`, `pc_valid_o` and the flags are registered and update on that edge (1-cycle latency).
- No combinational path from inputs to outputs.
- Asserting `rst_n` low mid-run forces the reset values immediately, independent of `clk`. The first `start_i` after release is honoured on the next edge.
- RAS push and pop complete in the same edge as the PC update. A return issued the cycle after a call returns correctly.

## Structure
- **Package `fetch_pkg`:** `state_t` enum (IDLE/RUN/HALT) and `BR_ABS`/`BR_REL` constants.
- **Sub-module `ras_stack`:**
  - Parameters: PC_WIDTH, RAS_DEPTH.
  - Inputs: push, pop, clear, data in.
  - Outputs: top, empty, full, overflow/underflow pulses.
  - Implementation: circular pointer plus a count of width $clog2(RAS_DEPTH+1).
- **`fetch_seq`:** FSM, next-PC mux and sticky flags.

## Test plan
- **Reset and start:** reset, start with address 0x0005 for 1 cycle → PC sequence 5, 6, 7, …; `pc_valid_o`=1; `state_o`=1.
- **Branches:**
  - Absolute branch to 0x0020 at PC 7 → next PC 0x0020.
  - Relative branch with offset 0xFFFE at PC 0x0020 → 0x001E.
- **Stall and halt:** stall 3 cycles at PC 9 → PC stays 9, then 10. Halt → `state_o`=2 and PC frozen. Start with address 0 → PC 0, state RUN.
- **Nested calls:**
  - Call 0x40 at PC 3 → PC 0x40.
  - Call 0x80 → PC 0x80.
  - Ret → 0x41; ret → 4.
  - Further ret → 5 with `ras_underflow_o`=1.
- **RAS overflow (RAS_DEPTH=4):** 5 calls → `ras_overflow_o`=1; 4 rets return the last 4 addresses; the 5th ret underflows.
- **Wrap and precedence:**
  - PC 0xFFFF increments to 0x0000.
  - `ret_i` and `call_i` together → pop only.
  - Async reset asserted mid-cycle → `pc_o` 0 before the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

    // Sequencer run state, encoded as exposed on state_o.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // branch_mode_i encodings.
    localparam logic BR_ABS = 1'b0;
    localparam logic BR_REL = 1'b1;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push while full overwrites the oldest entry;
// a pop while empty leaves the stack untouched. Overflow/underflow are
// single-cycle combinational pulses qualified by the request inputs.
module ras_stack
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH  = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic                clear_i,
    input  logic [PC_WIDTH-1:0] data_i,
    output logic [PC_WIDTH-1:0] top_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       ptr_inc, ptr_dec;
    logic                do_push, do_pop;

    assign ptr_inc = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_dec = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - 1'b1;

    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == CW'(RAS_DEPTH));
    assign top_o       = mem_q[ptr_q];
    // Pop wins if both are requested; clear overrides everything.
    assign do_pop      = pop_i && !clear_i && !empty_o;
    assign do_push     = push_i && !pop_i && !clear_i;
    assign overflow_o  = do_push && full_o;
    assign underflow_o = pop_i && !clear_i && empty_o;

    // Next pointer and occupancy count.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (do_pop) begin
            ptr_d = ptr_dec;
            cnt_d = cnt_q - 1'b1;
        end else if (do_push) begin
            ptr_d = ptr_inc;
            if (!full_o) cnt_d = cnt_q + 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; a push writes the slot above the current top.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[ptr_inc] <= data_i;
    end

endmodule

// File: rtl/fetch_seq.sv
// Program-counter sequencer: run/halt FSM, next-PC selection (sequential,
// absolute/relative branch, call, return) and sticky RAS error flags.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH  = 16,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [PC_WIDTH-1:0] start_address_i,
    input  logic                halt_i,
    input  logic                stall_i,
    input  logic                branch_i,
    input  logic                branch_mode_i,
    input  logic [PC_WIDTH-1:0] branchloc_i,
    input  logic                call_i,
    input  logic                ret_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                pc_valid_o,
    output logic [1:0]          state_o,
    output logic                ras_overflow_o,
    output logic                ras_underflow_o
);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                pc_valid_q;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic [PC_WIDTH-1:0] seq_pc, target;
    logic                ras_push, ras_pop, ras_clear;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_empty, ras_full, ras_ovf, ras_unf;

    // Arithmetic is truncated to PC_WIDTH, so wrap-around is silent.
    assign seq_pc = pc_q + PC_WIDTH'(STEP);
    assign target = (branch_mode_i == BR_REL) ? pc_q + branchloc_i : branchloc_i;

    ras_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .clear_i     (ras_clear),
        .data_i      (seq_pc),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full),
        .overflow_o  (ras_ovf),
        .underflow_o (ras_unf)
    );

    // Next state, next PC and RAS requests; one action per cycle by priority.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pc_d      = start_address_i;
                    state_d   = RUN;
                    ras_clear = 1'b1;
                end
            end
            RUN: begin
                if (start_i) begin
                    pc_d      = start_address_i;
                    ras_clear = 1'b1;
                end else if (halt_i) begin
                    state_d = HALT;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (ret_i) begin
                    ras_pop = 1'b1;
                    pc_d    = ras_empty ? seq_pc : ras_top;
                end else if (call_i) begin
                    ras_push = 1'b1;
                    pc_d     = target;
                end else if (branch_i) begin
                    pc_d = target;
                end else begin
                    pc_d = seq_pc;
                end
            end
            HALT: begin
                if (start_i) begin
                    pc_d      = start_address_i;
                    state_d   = RUN;
                    ras_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // ras_full is only observed through the overflow pulse.
        ovf_d = ras_clear ? 1'b0 : (ovf_q | ras_ovf | (ras_full & 1'b0));
        unf_d = ras_clear ? 1'b0 : (unf_q | ras_unf);
    end

    // State, PC and flag registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= (state_d == RUN);
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign pc_o            = pc_q;
    assign pc_valid_o      = pc_valid_q;
    assign state_o         = state_q;
    assign ras_overflow_o  = ovf_q;
    assign ras_underflow_o = unf_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed test for fetch_seq: driver pushes hand-computed expected outputs,
// a monitor pops and compares them one clock after each issued cycle.
module tb_fetch_seq;

    localparam int W = 21; // {pc[15:0], state[1:0], valid, ovf, unf}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] start_address_i = '0;
    logic        halt_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic        branch_mode_i = 1'b0;
    logic [15:0] branchloc_i = '0;
    logic        call_i = 1'b0;
    logic        ret_i = 1'b0;
    logic [15:0] pc_o;
    logic        pc_valid_o;
    logic [1:0]  state_o;
    logic        ras_overflow_o;
    logic        ras_underflow_o;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int vec = 0;

    fetch_seq #(.PC_WIDTH(16), .STEP(1), .RAS_DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .start_address_i (start_address_i),
        .halt_i          (halt_i),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_mode_i   (branch_mode_i),
        .branchloc_i     (branchloc_i),
        .call_i          (call_i),
        .ret_i           (ret_i),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .state_o         (state_o),
        .ras_overflow_o  (ras_overflow_o),
        .ras_underflow_o (ras_underflow_o)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs at the falling edge and queue the expectation.
    task automatic cyc(input logic st, input logic [15:0] sa, input logic hl, input logic sl,
                       input logic br, input logic md, input logic [15:0] loc,
                       input logic cl, input logic rt,
                       input logic [15:0] e_pc, input logic [1:0] e_st,
                       input logic e_ov, input logic e_un);
        @(negedge clk);
        start_i = st; start_address_i = sa; halt_i = hl; stall_i = sl;
        branch_i = br; branch_mode_i = md; branchloc_i = loc; call_i = cl; ret_i = rt;
        exp_q.push_back({e_pc, e_st, (e_st == 2'd1), e_ov, e_un});
    endtask

    task automatic t_nop(input logic [15:0] e, input logic [1:0] s, input logic ov, input logic un);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, e, s, ov, un);
    endtask
    task automatic t_start(input logic [15:0] a, input logic [15:0] e);
        cyc(1, a, 0, 0, 0, 0, 0, 0, 0, e, 2'd1, 0, 0);
    endtask
    task automatic t_br(input logic md, input logic [15:0] loc, input logic [15:0] e,
                        input logic [1:0] s, input logic ov, input logic un);
        cyc(0, 0, 0, 0, 1, md, loc, 0, 0, e, s, ov, un);
    endtask
    task automatic t_call(input logic md, input logic [15:0] loc, input logic [15:0] e,
                          input logic ov, input logic un);
        cyc(0, 0, 0, 0, 0, md, loc, 1, 0, e, 2'd1, ov, un);
    endtask
    task automatic t_ret(input logic [15:0] e, input logic ov, input logic un);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, e, 2'd1, ov, un);
    endtask

    // Monitor: compare the registered outputs just after each rising edge.
    initial begin
        logic [W-1:0] exp_v, act_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {pc_o, state_o, pc_valid_o, ras_overflow_o, ras_underflow_o};
                vec++;
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL vec%0d: actual pc=%h st=%0d v=%b ov=%b un=%b required pc=%h st=%0d v=%b ov=%b un=%b",
                             vec, act_v[20:5], act_v[4:3], act_v[2], act_v[1], act_v[0],
                             exp_v[20:5], exp_v[4:3], exp_v[2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    // Direct check of outputs (used around reset, outside the queue).
    task automatic check_reset(input string name);
        checks++;
        if ({pc_o, state_o, pc_valid_o, ras_overflow_o, ras_underflow_o} !== '0) begin
            errors++;
            $display("FAIL %s: actual pc=%h st=%0d v=%b ov=%b un=%b required all zero",
                     name, pc_o, state_o, pc_valid_o, ras_overflow_o, ras_underflow_o);
        end
    endtask

    // Stimulus.
    initial begin
        repeat (2) @(posedge clk);
        #1 check_reset("reset_values");
        @(negedge clk) rst_n = 1'b1;

        // IDLE ignores everything but start.
        t_br(0, 16'h0033, 16'h0000, 2'd0, 0, 0);
        t_start(16'h0005, 16'h0005);
        t_nop(16'h0006, 2'd1, 0, 0);
        t_nop(16'h0007, 2'd1, 0, 0);
        // Absolute and relative branches.
        t_br(0, 16'h0020, 16'h0020, 2'd1, 0, 0);
        t_br(1, 16'hFFFE, 16'h001E, 2'd1, 0, 0);
        t_br(0, 16'h0009, 16'h0009, 2'd1, 0, 0);
        // Stall three cycles, then advance.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0009, 2'd1, 0, 0);
        t_nop(16'h000A, 2'd1, 0, 0);
        // Halt freezes the PC; branches are ignored in HALT.
        cyc(0, 0, 1, 1, 0, 0, 0, 0, 0, 16'h000A, 2'd2, 0, 0);
        t_br(0, 16'h0033, 16'h000A, 2'd2, 0, 0);
        t_start(16'h0000, 16'h0000);
        t_nop(16'h0001, 2'd1, 0, 0);
        t_nop(16'h0002, 2'd1, 0, 0);
        t_nop(16'h0003, 2'd1, 0, 0);
        // Nested calls and returns, then underflow.
        t_call(0, 16'h0040, 16'h0040, 0, 0);
        t_call(0, 16'h0080, 16'h0080, 0, 0);
        t_ret(16'h0041, 0, 0);
        t_ret(16'h0004, 0, 0);
        t_ret(16'h0005, 0, 1);
        // Start held two cycles reloads and clears flags.
        t_start(16'h0100, 16'h0100);
        t_start(16'h0100, 16'h0100);
        t_nop(16'h0101, 2'd1, 0, 0);
        // Five calls overflow a depth-4 stack.
        t_call(0, 16'h0200, 16'h0200, 0, 0);
        t_call(0, 16'h0300, 16'h0300, 0, 0);
        t_call(0, 16'h0400, 16'h0400, 0, 0);
        t_call(0, 16'h0500, 16'h0500, 0, 0);
        t_call(0, 16'h0600, 16'h0600, 1, 0);
        t_ret(16'h0501, 1, 0);
        t_ret(16'h0401, 1, 0);
        t_ret(16'h0301, 1, 0);
        t_ret(16'h0201, 1, 0);
        t_ret(16'h0202, 1, 1);
        // Relative call; ret+call pops only; call+branch acts as call.
        t_call(1, 16'h0010, 16'h0212, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 16'h0700, 1, 1, 16'h0203, 2'd1, 1, 1);
        t_ret(16'h0204, 1, 1);
        cyc(0, 0, 0, 0, 1, 0, 16'h0050, 1, 0, 16'h0050, 2'd1, 1, 1);
        t_ret(16'h0205, 1, 1);
        // Wrap-around.
        t_br(0, 16'hFFFF, 16'hFFFF, 2'd1, 1, 1);
        t_nop(16'h0000, 2'd1, 1, 1);
        // Restart from HALT clears the sticky flags.
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd2, 1, 1);
        t_start(16'h0010, 16'h0010);
        t_nop(16'h0011, 2'd1, 0, 0);
        t_nop(16'h0012, 2'd1, 0, 0);

        // Asynchronous reset mid-cycle, observed before the next rising edge.
        @(negedge clk);
        start_i = 0; halt_i = 0; stall_i = 0; branch_i = 0; call_i = 0; ret_i = 0;
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        @(negedge clk) rst_n = 1'b1;
        t_start(16'h0007, 16'h0007);
        t_nop(16'h0008, 2'd1, 0, 0);
        t_nop(16'h0009, 2'd1, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
